// File: rtl/local_result_pkg.sv
// Shared types and defaults for the local result memory tile scheduler.
package local_result_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer flips to the other requester after each grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  // A lone requester always wins; on contention the pointer picks the winner
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (|gnt) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/local_result_sched.sv
// Tile scheduler: fills the result memory from two producers, then drains the tile
// to the output bus with a registered valid/ready stage.
module local_result_sched
  import local_result_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic [$clog2(DEPTH):0]   cfg_len,
  input  logic                     wr0_valid,
  input  logic [DATA_W-1:0]        wr0_data,
  output logic                     wr0_ready,
  input  logic                     wr1_valid,
  input  logic [DATA_W-1:0]        wr1_data,
  output logic                     wr1_ready,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     rd_ready,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_waddr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_re,
  output logic [$clog2(DEPTH)-1:0] mem_raddr,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err_start
);

  localparam int unsigned AW = $clog2(DEPTH);
  // One extra counter bit so a full-depth tile does not wrap
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] LEN_MAX = CW'(DEPTH);

  state_e        state;
  state_e        state_nxt;
  logic [CW-1:0] len_q;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] ack_cnt;
  logic          rd_inflight;

  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          fill_en;
  logic          len_ok;
  logic          start_ok;
  logic          rd_hs;
  logic          issue;

  assign req     = {wr1_valid, wr0_valid};
  assign fill_en = (state == FILL);

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (fill_en),
    .req (req),
    .gnt (gnt)
  );

  // Next-state, handshake decode and memory port drive
  always_comb begin
    state_nxt = state;
    len_ok    = (cfg_len != '0) && (cfg_len <= LEN_MAX);
    start_ok  = cfg_start && len_ok && (state == IDLE);
    rd_hs     = rd_valid && rd_ready;
    issue     = (state == DRAIN) && (rd_cnt < len_q) && !rd_inflight &&
                (!rd_valid || rd_ready);

    wr0_ready = gnt[0];
    wr1_ready = gnt[1];
    mem_we    = |gnt;
    mem_waddr = mem_we ? wr_cnt[AW-1:0] : '0;
    case (gnt)
      2'b01:   mem_wdata = wr0_data;
      2'b10:   mem_wdata = wr1_data;
      default: mem_wdata = '0;
    endcase
    mem_re    = issue;
    mem_raddr = issue ? rd_cnt[AW-1:0] : '0;
    busy      = (state == FILL) || (state == DRAIN);
    done      = (state == DONE);

    case (state)
      IDLE:    if (start_ok) state_nxt = FILL;
      FILL:    if (mem_we && (CW'(wr_cnt + 1'b1) == len_q)) state_nxt = DRAIN;
      DRAIN:   if (rd_hs && (CW'(ack_cnt + 1'b1) == len_q)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Tile length and progress counters, cleared when a tile is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q   <= '0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      ack_cnt <= '0;
    end else if (start_ok) begin
      len_q   <= cfg_len;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      ack_cnt <= '0;
    end else begin
      if (mem_we) wr_cnt  <= CW'(wr_cnt + 1'b1);
      if (issue)  rd_cnt  <= CW'(rd_cnt + 1'b1);
      if (rd_hs)  ack_cnt <= CW'(ack_cnt + 1'b1);
    end
  end

  // Drain output register; read data lands one cycle after issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_inflight <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      rd_inflight <= issue;
      if (rd_inflight) begin
        rd_valid <= 1'b1;
        rd_data  <= mem_rdata;
      end else if (rd_hs) begin
        rd_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_start <= 1'b0;
    end else begin
      err_start <= cfg_start && !start_ok;
    end
  end

endmodule

// File: tb/tb_local_result_sched.sv
// Directed bench for local_result_sched with a behavioural one-cycle-latency memory.
module tb_local_result_sched;

  logic        clk;
  logic        rst;
  logic        cfg_start;
  logic [4:0]  cfg_len;
  logic        wr0_valid;
  logic [31:0] wr0_data;
  logic        wr0_ready;
  logic        wr1_valid;
  logic [31:0] wr1_data;
  logic        wr1_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_ready;
  logic        mem_we;
  logic [3:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic [3:0]  mem_raddr;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        err_start;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_word [16];
  logic [31:0] mem_model [16];

  local_result_sched #(.DATA_W(32), .DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_len   (cfg_len),
    .wr0_valid (wr0_valid),
    .wr0_data  (wr0_data),
    .wr0_ready (wr0_ready),
    .wr1_valid (wr1_valid),
    .wr1_data  (wr1_data),
    .wr1_ready (wr1_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .err_start (err_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem_model[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem_model[mem_raddr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic start_tile(input int len);
    cfg_start = 1'b1;
    cfg_len   = 5'(len);
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic fill_from_wr0(input int len, input logic [31:0] base);
    for (int i = 0; i < len; i++) begin
      wr0_valid   = 1'b1;
      wr0_data    = base + 32'(i);
      exp_word[i] = base + 32'(i);
      #1;
      n_cmp++;
      if (wr0_ready !== 1'b1 || wr1_ready !== 1'b0 || mem_we !== 1'b1 ||
          mem_waddr !== 4'(i) || mem_wdata !== exp_word[i]) begin
        n_err++;
        $display("FAIL fill_wr0[%0d]: rdy0=%b rdy1=%b we=%b addr=%0d data=%h, want 1 0 1 %0d %h",
                 i, wr0_ready, wr1_ready, mem_we, mem_waddr, mem_wdata, i, exp_word[i]);
      end
      @(negedge clk);
    end
    wr0_valid = 1'b0;
  endtask

  task automatic drain_tile(input int len, input int first);
    int got    = 0;
    int issued = first;
    bit fin    = 1'b0;
    rd_ready = 1'b1;
    for (int cyc = 0; cyc < 4 * len + 8 && !fin; cyc++) begin
      #1;
      if (got == len) begin
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0 || mem_re !== 1'b0) begin
          n_err++;
          $display("FAIL drain_done: done=%b busy=%b rd_valid=%b mem_re=%b, want 1 0 0 0",
                   done, busy, rd_valid, mem_re);
        end
        n_cmp++;
        if (issued !== len) begin
          n_err++;
          $display("FAIL drain_issue_count: got %0d reads, want %0d", issued, len);
        end
        fin = 1'b1;
      end else begin
        if (mem_re) begin
          n_cmp++;
          if (mem_raddr !== 4'(issued)) begin
            n_err++;
            $display("FAIL drain_raddr: got %0d, want %0d", mem_raddr, issued);
          end
          issued++;
        end
        if (rd_valid) begin
          n_cmp++;
          if (rd_data !== exp_word[got]) begin
            n_err++;
            $display("FAIL drain_data[%0d]: got %h, want %h", got, rd_data, exp_word[got]);
          end
          got++;
        end
      end
      @(negedge clk);
    end
    if (!fin) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d words, want %0d", got, len);
    end
    rd_ready = 1'b0;
    #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_width: done=%b busy=%b after done cycle, want 0 0", done, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({wr0_ready, wr1_ready, rd_valid, mem_we, mem_re, busy, done, err_start} !== 8'h00 ||
        rd_data !== 32'h0 || mem_waddr !== 4'h0 || mem_raddr !== 4'h0 || mem_wdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: flags=%b rd_data=%h, want all zero",
               {wr0_ready, wr1_ready, rd_valid, mem_we, mem_re, busy, done, err_start}, rd_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    // Park a len=4 tile in DRAIN with a word waiting, then reset it
    start_tile(4);
    fill_from_wr0(4, 32'h0000_0100);
    rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (rd_valid !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_setup: rd_valid=%b busy=%b, want 1 1", rd_valid, busy);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({wr0_ready, wr1_ready, rd_valid, mem_we, mem_re, busy, done, err_start} !== 8'h00 ||
        rd_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid_drain: flags=%b rd_data=%h, want all zero",
               {wr0_ready, wr1_ready, rd_valid, mem_we, mem_re, busy, done, err_start}, rd_data);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || rd_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_no_done[%0d]: done=%b busy=%b rd_valid=%b, want 0 0 0",
                 i, done, busy, rd_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single;
    start_tile(3);
    fill_from_wr0(3, 32'h0000_000A);
    drain_tile(3, 0);
  endtask

  task automatic test_contention;
    int  c0 = 0;
    int  c1 = 0;
    bit  exp_g0;
    logic [31:0] expw;
    // Reset puts the round-robin pointer back on producer 0
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    start_tile(4);
    wr0_valid = 1'b1;
    wr1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr0_data = 32'hC000_0000 + 32'(c0);
      wr1_data = 32'hB000_0000 + 32'(c1);
      #1;
      exp_g0      = ((i % 2) == 0);
      expw        = exp_g0 ? wr0_data : wr1_data;
      exp_word[i] = expw;
      n_cmp++;
      if (wr0_ready !== exp_g0 || wr1_ready !== !exp_g0 || mem_waddr !== 4'(i) ||
          mem_wdata !== expw) begin
        n_err++;
        $display("FAIL contention[%0d]: rdy=%b%b addr=%0d data=%h, want rdy=%b%b addr=%0d data=%h",
                 i, wr1_ready, wr0_ready, mem_waddr, mem_wdata, !exp_g0, exp_g0, i, expw);
      end
      if (exp_g0) c0++;
      else        c1++;
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (wr0_ready !== 1'b0 || wr1_ready !== 1'b0 || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL ready_outside_fill: rdy0=%b rdy1=%b we=%b, want 0 0 0",
               wr0_ready, wr1_ready, mem_we);
    end
    wr0_valid = 1'b0;
    wr1_valid = 1'b0;
    drain_tile(4, 0);
  endtask

  task automatic test_backpressure;
    int re_cnt = 0;
    start_tile(2);
    for (int i = 0; i < 2; i++) begin
      wr1_valid   = 1'b1;
      wr1_data    = 32'h5A5A_0000 + 32'(i);
      exp_word[i] = 32'h5A5A_0000 + 32'(i);
      #1;
      n_cmp++;
      if (wr1_ready !== 1'b1 || wr0_ready !== 1'b0 || mem_we !== 1'b1 ||
          mem_waddr !== 4'(i) || mem_wdata !== exp_word[i]) begin
        n_err++;
        $display("FAIL fill_wr1[%0d]: rdy1=%b rdy0=%b we=%b addr=%0d data=%h, want 1 0 1 %0d %h",
                 i, wr1_ready, wr0_ready, mem_we, mem_waddr, mem_wdata, i, exp_word[i]);
      end
      @(negedge clk);
    end
    wr1_valid = 1'b0;
    rd_ready  = 1'b0;
    for (int c = 0; c < 7; c++) begin
      #1;
      if (mem_re) re_cnt++;
      if (c >= 2) begin
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== exp_word[0]) begin
          n_err++;
          $display("FAIL backpressure_hold[%0d]: rd_valid=%b rd_data=%h, want 1 %h",
                   c, rd_valid, rd_data, exp_word[0]);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (re_cnt !== 1) begin
      n_err++;
      $display("FAIL backpressure_reads: got %0d mem_re, want 1", re_cnt);
    end
    drain_tile(2, 1);
  endtask

  task automatic test_cfg_err;
    int bad_len [2] = '{0, 17};
    for (int k = 0; k < 2; k++) begin
      cfg_start = 1'b1;
      cfg_len   = 5'(bad_len[k]);
      @(negedge clk);
      cfg_start = 1'b0;
      #1;
      n_cmp++;
      if (err_start !== 1'b1 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL cfg_bad_len(%0d): err_start=%b busy=%b, want 1 0", bad_len[k], err_start, busy);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (err_start !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL cfg_err_pulse(%0d): err_start=%b busy=%b, want 0 0", bad_len[k], err_start, busy);
      end
      @(negedge clk);
    end
    // Restart request in the middle of a fill must not disturb the tile
    start_tile(2);
    cfg_start   = 1'b1;
    cfg_len     = 5'd5;
    wr0_valid   = 1'b1;
    wr0_data    = 32'h0000_00E0;
    exp_word[0] = 32'h0000_00E0;
    #1;
    n_cmp++;
    if (wr0_ready !== 1'b1 || mem_waddr !== 4'd0 || err_start !== 1'b0) begin
      n_err++;
      $display("FAIL cfg_fill_w0: rdy0=%b addr=%0d err=%b, want 1 0 0", wr0_ready, mem_waddr, err_start);
    end
    @(negedge clk);
    cfg_start   = 1'b0;
    wr0_data    = 32'h0000_00E1;
    exp_word[1] = 32'h0000_00E1;
    #1;
    n_cmp++;
    if (err_start !== 1'b1 || busy !== 1'b1 || mem_we !== 1'b1 || mem_waddr !== 4'd1) begin
      n_err++;
      $display("FAIL cfg_start_in_fill: err=%b busy=%b we=%b addr=%0d, want 1 1 1 1",
               err_start, busy, mem_we, mem_waddr);
    end
    @(negedge clk);
    wr0_valid = 1'b0;
    drain_tile(2, 0);
  endtask

  task automatic test_full_depth;
    start_tile(16);
    fill_from_wr0(16, 32'hF000_0000);
    drain_tile(16, 0);
  endtask

  initial begin
    rst       = 1'b0;
    cfg_start = 1'b0;
    cfg_len   = 5'd0;
    wr0_valid = 1'b0;
    wr0_data  = 32'h0;
    wr1_valid = 1'b0;
    wr1_data  = 32'h0;
    rd_ready  = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_cfg_err();
    test_full_depth();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
